// File: rtl/complete_arbiter_pkg.sv
// Shared completion-path types: the FU result packet and the registered CDB lane.
package complete_arbiter_pkg;

  localparam int NUM_FU = 8;
  localparam int CDB_W  = 2;

  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_pr;
    logic [4:0]  rob_entry;
    logic [31:0] dest_value;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic              valid;
    FU_COMPLETE_PACKET pkt;
  } CDB_PACKET;

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-side request/stall bundle plus the registered CDB broadcast.
interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = complete_arbiter_pkg::NUM_FU,
  parameter int CDB_W  = complete_arbiter_pkg::CDB_W
);
  logic              [NUM_FU-1:0] want_to_complete;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet;
  logic              [NUM_FU-1:0] complete_stall;
  logic              [CDB_W-1:0]  cdb_valid;
  FU_COMPLETE_PACKET [CDB_W-1:0]  cdb_packet;

  modport master (output want_to_complete, fu_packet,
                  input  complete_stall, cdb_valid, cdb_packet);
  modport slave  (input  want_to_complete, fu_packet,
                  output complete_stall, cdb_valid, cdb_packet);
endinterface

// File: rtl/complete_arbiter_rr_multi_grant.sv
// Combinational round-robin picker: first CDB_W requesters scanning from ptr, k-th hit on lane k.
module rr_multi_grant #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 2,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]           req_i,
  input  logic [IDX_W-1:0]            ptr_i,
  output logic [NUM_FU-1:0]           grant_o,
  output logic [CDB_W-1:0]            lane_vld_o,
  output logic [CDB_W-1:0][IDX_W-1:0] lane_idx_o,
  output logic [IDX_W-1:0]            last_idx_o
);

  always_comb begin
    int              cnt;
    int              s;
    logic [IDX_W-1:0] idx;
    grant_o    = '0;
    lane_vld_o = '0;
    lane_idx_o = '0;
    last_idx_o = ptr_i;
    cnt        = 0;
    s          = 0;
    idx        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      s = int'(ptr_i) + k;
      if (s >= NUM_FU) s = s - NUM_FU;
      idx = s[IDX_W-1:0];
      if (req_i[idx] && cnt < CDB_W) begin
        grant_o[idx] = 1'b1;
        last_idx_o   = idx;
        for (int l = 0; l < CDB_W; l++) begin
          if (l == cnt) begin
            lane_vld_o[l] = 1'b1;
            lane_idx_o[l] = idx;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: grants up to CDB_W FUs per cycle round-robin and registers them onto the CDB.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = complete_arbiter_pkg::NUM_FU,
  parameter int CDB_W  = complete_arbiter_pkg::CDB_W,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             squash_i,
  output logic [IDX_W-1:0] rr_ptr_o,
  complete_arbiter_if.slave bus
);

  logic [NUM_FU-1:0]           grant;
  logic [CDB_W-1:0]            lane_vld;
  logic [CDB_W-1:0][IDX_W-1:0] lane_idx;
  logic [IDX_W-1:0]            last_idx;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  CDB_PACKET [CDB_W-1:0]       cdb_q, cdb_d;

  rr_multi_grant #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .IDX_W(IDX_W)) u_pick (
    .req_i      (bus.want_to_complete),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .lane_vld_o (lane_vld),
    .lane_idx_o (lane_idx),
    .last_idx_o (last_idx)
  );

  // Squash wins over every request: nothing granted, nothing stalled.
  always_comb begin
    int t;
    bus.complete_stall = '0;
    rr_ptr_d           = rr_ptr_q;
    cdb_d              = '0;
    t                  = int'(last_idx) + 1;
    if (t >= NUM_FU) t = 0;
    if (rst_n && !squash_i) begin
      bus.complete_stall = bus.want_to_complete & ~grant;
      if (|grant) rr_ptr_d = t[IDX_W-1:0];
      for (int l = 0; l < CDB_W; l++) begin
        if (lane_vld[l]) begin
          cdb_d[l].valid = 1'b1;
          cdb_d[l].pkt   = bus.fu_packet[lane_idx[l]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  always_comb begin
    for (int l = 0; l < CDB_W; l++) begin
      bus.cdb_valid[l]  = cdb_q[l].valid;
      bus.cdb_packet[l] = cdb_q[l].pkt;
    end
  end

  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: vector table plus hand sequences for fairness, squash, reset.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       squash = 1'b0;
  logic [2:0] rr;
  int         n_pass = 0;
  int         n_tot  = 0;

  complete_arbiter_if #(.NUM_FU(8), .CDB_W(2)) bus ();

  complete_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .squash_i (squash),
    .rr_ptr_o (rr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] want;
    logic       sq;
    logic [7:0] stall;
    logic [1:0] vld;
    int         l0;
    int         l1;
    int         rr;
  } vec_t;

  vec_t tbl[11];

  function automatic FU_COMPLETE_PACKET mkp(int i);
    FU_COMPLETE_PACKET p;
    p.valid      = 1'b1;
    p.dest_pr    = 6'(i + 1);
    p.rob_entry  = 5'(i + 2);
    p.dest_value = 32'(100 + i);
    return p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_lane(string name, int lane, logic v, int fu);
    FU_COMPLETE_PACKET e;
    e = v ? mkp(fu) : '0;
    chk(name, 64'(bus.cdb_packet[lane]), 64'(e));
  endtask

  initial begin
    int gcnt[8];
    int run[8];
    int maxrun;

    // want, squash, stall, next cdb_valid, lane0 FU, lane1 FU, next rr_ptr
    tbl[0]  = '{8'h07, 1'b0, 8'h01, 2'b11, 1, 2, 3};
    tbl[1]  = '{8'h00, 1'b0, 8'h00, 2'b00, 0, 0, 3};
    tbl[2]  = '{8'hFF, 1'b1, 8'h00, 2'b00, 0, 0, 3};
    tbl[3]  = '{8'hFF, 1'b0, 8'hE7, 2'b11, 3, 4, 5};
    tbl[4]  = '{8'h81, 1'b0, 8'h00, 2'b11, 7, 0, 1};
    tbl[5]  = '{8'h40, 1'b0, 8'h00, 2'b01, 6, 0, 7};
    tbl[6]  = '{8'h81, 1'b0, 8'h00, 2'b11, 7, 0, 1};
    tbl[7]  = '{8'h14, 1'b0, 8'h00, 2'b11, 2, 4, 5};
    tbl[8]  = '{8'h0F, 1'b0, 8'h0C, 2'b11, 0, 1, 2};
    tbl[9]  = '{8'h01, 1'b0, 8'h00, 2'b01, 0, 0, 1};
    tbl[10] = '{8'h80, 1'b0, 8'h00, 2'b01, 7, 0, 0};

    for (int i = 0; i < 8; i++) bus.fu_packet[i] = mkp(i);
    bus.want_to_complete = 8'hFF;

    // reset held two cycles with every FU requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(bus.complete_stall), 64'h0);
    chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
    chk("rst_rr", 64'(rr), 64'h0);
    chk("rst_pkt", 64'(bus.cdb_packet), 64'h0);

    // single MULT completion
    @(negedge clk);
    rst_n = 1'b1;
    bus.want_to_complete = 8'h01;
    bus.fu_packet[0].dest_value = 32'd35;
    bus.fu_packet[0].dest_pr    = 6'd1;
    bus.fu_packet[0].rob_entry  = 5'd2;
    #1 chk("mul_stall", 64'(bus.complete_stall), 64'h0);
    @(posedge clk); #1;
    chk("mul_valid", 64'(bus.cdb_valid), 64'h1);
    chk("mul_value", 64'(bus.cdb_packet[0].dest_value), 64'd35);
    chk("mul_pr", 64'(bus.cdb_packet[0].dest_pr), 64'd1);
    chk("mul_rob", 64'(bus.cdb_packet[0].rob_entry), 64'd2);
    chk("mul_rr", 64'(rr), 64'd1);
    @(negedge clk);
    bus.fu_packet[0] = mkp(0);

    for (int v = 0; v < 11; v++) begin
      if (v > 0) @(negedge clk);
      bus.want_to_complete = tbl[v].want;
      squash = tbl[v].sq;
      #1 chk($sformatf("v%0d_stall", v), 64'(bus.complete_stall), 64'(tbl[v].stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", v), 64'(bus.cdb_valid), 64'(tbl[v].vld));
      chk_lane($sformatf("v%0d_lane0", v), 0, tbl[v].vld[0], tbl[v].l0);
      chk_lane($sformatf("v%0d_lane1", v), 1, tbl[v].vld[1], tbl[v].l1);
      chk($sformatf("v%0d_rr", v), 64'(rr), 64'(tbl[v].rr));
    end

    // three requesters from rr_ptr=0: FU2 waits one cycle
    @(negedge clk);
    squash = 1'b0;
    bus.want_to_complete = 8'h07;
    #1 chk("t3_stall", 64'(bus.complete_stall), 64'h04);
    @(posedge clk); #1;
    chk("t3_valid", 64'(bus.cdb_valid), 64'h3);
    chk_lane("t3_lane0", 0, 1'b1, 0);
    chk_lane("t3_lane1", 1, 1'b1, 1);
    chk("t3_rr", 64'(rr), 64'd2);
    @(negedge clk);
    bus.want_to_complete = 8'h04;
    #1 chk("t3b_stall", 64'(bus.complete_stall), 64'h0);
    @(posedge clk); #1;
    chk("t3b_valid", 64'(bus.cdb_valid), 64'h1);
    chk_lane("t3b_lane0", 0, 1'b1, 2);
    chk_lane("t3b_lane1", 1, 1'b0, 0);
    chk("t3b_rr", 64'(rr), 64'd3);
    @(negedge clk);
    bus.want_to_complete = 8'h80;
    @(posedge clk); #1;
    chk("t3c_rr", 64'(rr), 64'd0);

    // fairness: all FUs request for 8 cycles
    for (int i = 0; i < 8; i++) begin gcnt[i] = 0; run[i] = 0; end
    maxrun = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.want_to_complete = 8'hFF;
      #1;
      chk($sformatf("fair_rr%0d", c), 64'(rr), 64'((2 * c) % 8));
      for (int i = 0; i < 8; i++) begin
        if (bus.complete_stall[i]) begin
          run[i]++;
          if (run[i] > maxrun) maxrun = run[i];
        end else begin
          gcnt[i]++;
          run[i] = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) chk($sformatf("fair_cnt%0d", i), 64'(gcnt[i]), 64'd2);
    chk("fair_maxstall_le3", 64'(maxrun <= 3), 64'd1);
    @(posedge clk); #1;
    chk("fair_rr_end", 64'(rr), 64'd0);

    // squash overrides every request
    @(negedge clk);
    squash = 1'b1;
    #1 chk("sq_stall", 64'(bus.complete_stall), 64'h0);
    @(posedge clk); #1;
    chk("sq_valid", 64'(bus.cdb_valid), 64'h0);
    chk("sq_rr", 64'(rr), 64'd0);

    // async reset while a broadcast is on the CDB
    @(negedge clk);
    squash = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(bus.cdb_valid), 64'h3);
    chk("pre_rst_rr", 64'(rr), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.cdb_valid), 64'h0);
    chk("mid_rst_pkt", 64'(bus.cdb_packet), 64'h0);
    chk("mid_rst_rr", 64'(rr), 64'd0);
    chk("mid_rst_stall", 64'(bus.complete_stall), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.want_to_complete = 8'h00;
    @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
